// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets an instruction-side and a
// data-side cache controller share one SRAM controller. It keeps at most one
// line transaction in flight and returns the response to the port that issued
// it. A saturating watchdog raises a sticky error if memory never completes.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_rw,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                mem_valid,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                gnt_id,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [15:0] WD_MAX    = 16'hFFFF;

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                gnt_q, gnt_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          req_ready_q, req_ready_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [15:0]         wd_q, wd_d;

  logic                pick_s;
  logic [15:0]         wd_inc_s;

  // Round-robin choice and saturating watchdog increment.
  always_comb begin
    if (req_valid == 2'b11) begin
      pick_s = ~last_gnt_q;
    end else begin
      pick_s = req_valid[1];
    end
    if (wd_q == WD_MAX) begin
      wd_inc_s = WD_MAX;
    end else begin
      wd_inc_s = wd_q + 16'd1;
    end
  end

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    mem_valid_d = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ready_d = 2'b00;
    req_rdata_d = req_rdata_q;
    busy_d      = 1'b0;
    err_d       = err_q;
    wd_d        = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          state_d     = ST_BUSY;
          last_gnt_d  = pick_s;
          gnt_d       = pick_s;
          mem_rw_d    = req_rw[pick_s];
          mem_addr_d  = pick_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          mem_wdata_d = pick_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          mem_valid_d = 1'b1;
          busy_d      = 1'b1;
          wd_d        = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        busy_d = 1'b1;
        if (mem_ready) begin
          // Completion: hand the line back and pulse the owner's ready next cycle.
          state_d     = ST_RESP;
          req_rdata_d = mem_rdata;
          req_ready_d = gnt_q ? 2'b10 : 2'b01;
        end else begin
          // Keep waiting; the watchdog only reports, it never aborts.
          mem_valid_d = 1'b1;
          wd_d        = wd_inc_s;
          err_d       = err_q | (wd_inc_s >= TIMEOUT_C);
        end
      end
      ST_RESP: begin
        // No grant here so the finishing requester cannot be served twice.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      gnt_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_ready_q <= 2'b00;
      req_rdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt_id    = gnt_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: per-port requesters, a memory model and a
// scoreboard of expected memory transactions and responses.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TO = 4;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]    req_valid, req_rw, req_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] req_rdata, mem_wdata, mem_rdata;
  logic          mem_valid, mem_rw, mem_ready, gnt_id, busy, err;
  logic [AW-1:0] mem_addr;

  logic          rv0, rv1, rw0, rw1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] w0, w1;
  assign req_valid = {rv1, rv0};
  assign req_rw    = {rw1, rw0};
  assign req_addr  = {a1, a0};
  assign req_wdata = {w1, w0};

  req_t pq0[$];
  req_t pq1[$];
  exp_t exp_mem[$];
  exp_t exp_rsp[$];

  int total = 0;
  int bad = 0;
  int mem_txn = 0;
  int mem_lat = 0;
  bit mem_block = 1'b0;
  int late_req = 0;
  int late_ack = 0;
  bit mm_active = 1'b0;
  int mm_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .gnt_id(gnt_id), .busy(busy), .err(err)
  );

  function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
    return {32'hDEADBEEF, a, ~a, 32'h00000001};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue a request on a port and record what memory and the port should see.
  task automatic issue(input logic p, input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    req_t r;
    exp_t e;
    r.rw = rw; r.addr = addr; r.wdata = wd;
    e.port = p; e.rw = rw; e.addr = addr; e.wdata = wd;
    if (p) pq1.push_back(r); else pq0.push_back(r);
    exp_mem.push_back(e);
    exp_rsp.push_back(e);
  endtask

  task automatic wait_mem_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 50);
    check_eq(tag, {127'd0, mem_valid}, 128'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 128'(exp_rsp.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_mem.delete();
    exp_rsp.delete();
  endtask

  // Requesters: hold each request until its ready pulse, change it the cycle after.
  initial begin : requester
    req_t r;
    logic [1:0] rdy_prev;
    rv0 = 1'b0; rv1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    a0 = '0; a1 = '0; w0 = '0; w1 = '0;
    rdy_prev = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rv0 = 1'b0; rv1 = 1'b0;
        pq0.delete(); pq1.delete();
        rdy_prev = 2'b00;
      end else begin
        if (rdy_prev[0] || !rv0) begin
          if (pq0.size() > 0) begin
            r = pq0.pop_front();
            rv0 = 1'b1; rw0 = r.rw; a0 = r.addr; w0 = r.wdata;
          end else rv0 = 1'b0;
        end
        if (rdy_prev[1] || !rv1) begin
          if (pq1.size() > 0) begin
            r = pq1.pop_front();
            rv1 = 1'b1; rw1 = r.rw; a1 = r.addr; w1 = r.wdata;
          end else rv1 = 1'b0;
        end
        rdy_prev = req_ready;
      end
    end
  end

  // Memory model: checks each new transaction, answers after mem_lat cycles.
  initial begin : mem_model
    exp_t e;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (late_req != late_ack) begin
        late_ack = late_req;
        mem_ready = 1'b1;
        mem_rdata = mem_line(32'hBAD0BAD0);
      end else if (mem_valid) begin
        if (!mm_active) begin
          mm_active = 1'b1;
          mm_cnt = 0;
          mem_txn++;
          if (exp_mem.size() == 0) begin
            check_eq("mem_unexpected", {127'd0, mem_valid}, 128'd0);
          end else begin
            e = exp_mem.pop_front();
            check_eq("mem_gnt", {127'd0, gnt_id}, {127'd0, e.port});
            check_eq("mem_rw", {127'd0, mem_rw}, {127'd0, e.rw});
            check_eq("mem_addr", {96'd0, mem_addr}, {96'd0, e.addr});
            check_eq("mem_busy", {127'd0, busy}, 128'd1);
            if (e.rw) check_eq("mem_wdata", mem_wdata, e.wdata);
          end
        end
        if (!mem_block && mm_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_line(mem_addr);
        end else begin
          mm_cnt++;
        end
      end else begin
        mm_active = 1'b0;
      end
    end
  end

  // Response monitor: each ready pulse must match the oldest expected response.
  initial begin : rsp_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        if (exp_rsp.size() == 0) begin
          check_eq("rsp_unexpected", {126'd0, req_ready}, 128'd0);
        end else begin
          e = exp_rsp.pop_front();
          check_eq("rsp_ready", {126'd0, req_ready}, e.port ? 128'd2 : 128'd1);
          check_eq("rsp_gnt", {127'd0, gnt_id}, {127'd0, e.port});
          check_eq("rsp_busy_memv", {126'd0, busy, mem_valid}, 128'd2);
          if (!e.rw) check_eq("rsp_rdata", req_rdata, mem_line(e.addr));
        end
      end
    end
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int t0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", {121'd0, req_ready, mem_valid, mem_rw, gnt_id, busy, err}, 128'd0);
    check_eq("rst_rdata", req_rdata, 128'd0);
    check_eq("rst_addr", {96'd0, mem_addr}, 128'd0);
    check_eq("rst_wdata", mem_wdata, 128'd0);
    rst = 1'b0;

    // Single read on port 0, memory answers after 3 cycles.
    mem_lat = 3;
    issue(1'b0, 1'b0, 32'h100, 128'd0);
    wait_mem_valid("t1_mem_valid");
    check_eq("t1_addr", {96'd0, mem_addr}, 128'h100);
    check_eq("t1_rw", {127'd0, mem_rw}, 128'd0);
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t1_ready", {126'd0, req_ready}, 128'd1);
    check_eq("t1_rdata", req_rdata, mem_line(32'h100));
    @(negedge clk);
    check_eq("t1_ready_once", {126'd0, req_ready}, 128'd0);
    check_eq("t1_busy_low", {127'd0, busy}, 128'd0);
    check_eq("t1_err", {127'd0, err}, 128'd0);

    // Simultaneous requests from reset: port 0 first, then the port 1 write.
    do_reset();
    mem_lat = 1;
    issue(1'b0, 1'b0, 32'h10, 128'd0);
    issue(1'b1, 1'b1, 32'h20, {16{8'hA5}});
    wait_done("t2_done");

    // Continuous contention: grants alternate 0,1,0,1,0,1.
    mem_lat = 2;
    t0 = mem_txn;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, i[0], 32'h300 + 32'(i), {4{32'(i) ^ 32'h13579BDF}});
      issue(1'b1, ~i[0], 32'h380 + 32'(i), {4{32'(i) ^ 32'h2468ACE0}});
    end
    wait_done("t3_done");
    check_eq("t3_txn", 128'(mem_txn - t0), 128'd6);

    // Duplicate guard with minimum latency.
    mem_lat = 0;
    t0 = mem_txn;
    issue(1'b0, 1'b0, 32'h400, 128'd0);
    wait_mem_valid("t4_mem_valid");
    @(negedge clk);
    check_eq("t4_min_latency", {126'd0, req_ready}, 128'd1);
    repeat (8) @(negedge clk);
    check_eq("t4_single_txn", 128'(mem_txn - t0), 128'd1);
    check_eq("t4_idle", {127'd0, busy}, 128'd0);

    // Watchdog: memory withheld, err after TIMEOUT busy cycles, sticky.
    mem_block = 1'b1;
    issue(1'b0, 1'b0, 32'h500, 128'd0);
    wait_mem_valid("t5_mem_valid");
    repeat (3) @(negedge clk);
    check_eq("t5_err_early", {127'd0, err}, 128'd0);
    @(negedge clk);
    check_eq("t5_err_set", {127'd0, err}, 128'd1);
    repeat (6) @(negedge clk);
    check_eq("t5_still_waiting", {126'd0, err, mem_valid}, 128'd3);
    mem_block = 1'b0;
    wait_done("t5_done");
    check_eq("t5_err_sticky", {127'd0, err}, 128'd1);
    do_reset();
    check_eq("t5_err_cleared", {127'd0, err}, 128'd0);

    // Reset in BUSY, then a late mem_ready that must be ignored.
    mem_block = 1'b1;
    issue(1'b1, 1'b1, 32'h600, {8{16'h6666}});
    wait_mem_valid("t6_mem_valid");
    rst = 1'b1;
    @(negedge clk);
    exp_rsp.delete();
    check_eq("t6_rst_ctl", {121'd0, req_ready, mem_valid, mem_rw, gnt_id, busy, err}, 128'd0);
    check_eq("t6_rst_addr", {96'd0, mem_addr}, 128'd0);
    check_eq("t6_rst_wdata", mem_wdata, 128'd0);
    rst = 1'b0;
    mem_block = 1'b0;
    late_req++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t6_quiet", {124'd0, req_ready, mem_valid, busy}, 128'd0);
    end
    check_eq("end_mem_queue", 128'(exp_mem.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single SRAM controller between an instruction-side and a data-side cache controller. It sits between the cache controllers and the SRAM controller inside the memory hierarchy. It accepts at most one outstanding line transaction, forwards it unchanged to the memory side, and returns the response to the requester that issued it. A watchdog flags a memory transaction that never completes.

## Interface

Parameters:
- ADDR_W, 32, line address width
- DATA_W, 128, line data width
- TIMEOUT, 255, cycles without mem_ready before err is raised (1..65535)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  request valid per port; bit 0 = instruction side, bit 1 = data side
- req_rw  in  2  per port, 1 = write, 0 = read
- req_addr  in  2×ADDR_W  per-port address; port n in bits [n*ADDR_W +: ADDR_W]
- req_wdata  in  2×DATA_W  per-port write line
- req_ready  out  2  one-cycle completion pulse per port
- req_rdata  out  DATA_W  read line, shared; valid only while a req_ready bit is high
- mem_valid  out  1  request to SRAM controller
- mem_rw  out  1  1 = write
- mem_addr  out  ADDR_W  address to SRAM controller
- mem_wdata  out  DATA_W  write line to SRAM controller
- mem_ready  in  1  SRAM controller completion pulse
- mem_rdata  in  DATA_W  read line from SRAM controller; valid with mem_ready
- gnt_id  out  1  port currently owning memory; meaningful when busy = 1
- busy  out  1  high in BUSY and RESP
- err  out  1  sticky watchdog error

## Operation

- Requester protocol: hold req_valid and the fields stable until req_ready pulses. On the cycle after the pulse, either drop req_valid or present a new request.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise grant one port and go to BUSY. Latch that port's rw, addr and wdata into the mem_* output registers and set gnt_id.
- Round-robin grant:
  - Pointer last_gnt, reset value 1, so port 0 wins the first contention.
  - If both ports are valid, grant !last_gnt.
  - If one port is valid, grant it.
  - last_gnt updates to the granted port.
- BUSY:
  - mem_valid = 1 and the mem_* fields are held constant.
  - On mem_ready: register mem_rdata into req_rdata and go to RESP.
- RESP:
  - req_ready[gnt_id] = 1 for exactly this cycle; mem_valid = 0.
  - No grant is evaluated in RESP. This prevents re-granting a requester that has not yet seen its ready.
  - Next state is IDLE.
- Watchdog:
  - 16-bit counter, cleared on entry to BUSY, incremented each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT, err is set and stays set until rst.
  - The counter saturates. The transaction keeps waiting; nothing is aborted.
- req_ready is never asserted on both bits at once, and never on a port whose req_valid was low at grant time.
- mem_ready received outside BUSY is ignored.

## Timing

- Reset values: all outputs 0 (req_ready, req_rdata, mem_valid, mem_rw, mem_addr, mem_wdata, gnt_id, busy, err). FSM = IDLE, last_gnt = 1, watchdog = 0.
- rst asserted in any state returns to the reset values on the next edge, including mid-BUSY. A late mem_ready after reset is ignored.
- Request in IDLE sampled at edge t: mem_valid and busy are high from t+1.
- mem_ready sampled at edge k: RESP is cycle k+1, with req_ready pulse, req_rdata valid and mem_valid low.
- IDLE resumes at k+2; the earliest next mem_valid is at k+3.
- Minimum request-to-ready latency: mem_valid at t+1, mem_ready at t+1, req_ready at t+2, i.e. 2 cycles.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- A request that arrives while BUSY or RESP waits; it is considered on the first IDLE cycle.

## Test plan

- Single read, port 0:
  - Stimulus: addr 0x100 read, memory responds after 3 cycles with 0xDEADBEEF_…_01.
  - Required: mem_addr = 0x100, mem_rw = 0; req_ready = 2'b01 for one cycle; req_rdata matches; busy low again 2 cycles after mem_ready.
- Simultaneous requests from reset:
  - Stimulus: port 0 read 0x10 and port 1 write 0x20 with wdata 0xA5…A5, both held.
  - Required: port 0 served first, then port 1. Memory sees write 0x20 with 0xA5…A5. gnt_id sequence is 0, 1.
- Both ports requesting continuously for 6 transactions:
  - Required: grants alternate 0,1,0,1,0,1, and no port is served twice consecutively.
- Duplicate guard:
  - Stimulus: port 0 holds req_valid through the RESP cycle, drops it the next cycle; memory completes in 1 cycle.
  - Required: exactly one mem transaction is issued.
- Watchdog:
  - Stimulus: TIMEOUT = 4, mem_ready withheld.
  - Required: err rises after 4 BUSY cycles, stays high after a late mem_ready, and clears only on rst.
- Reset in BUSY:
  - Stimulus: assert rst while mem_valid = 1, then pulse mem_ready.
  - Required: all outputs 0, no req_ready pulse, state IDLE.
